fifo_access_sched: RTL and testbench

- Round-robin scheduler that shares the 8-bit, 32-entry fifo between two write producers and one read consumer.
- Drives the fifo's i_wreq/i_rreq so that at most one operation is issued per cycle. Write and read are never asserted together.
- Keeps its own shadow occupancy count, so it never writes when full or reads when empty.
- Provides a flush sequence that drains the fifo and discards the data.

---
 rtl/fifo_access_sched.sv | 129 ++++++++++++
 tb/tb_fifo_access_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_sched.sv
// Round-robin access scheduler: two write producers and one read consumer share
// a single fifo; at most one fifo operation is issued per cycle, with flush support.
module fifo_access_sched #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p0_wvalid,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_wready,
  input  logic              p1_wvalid,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_wready,
  input  logic              c_rreq,
  output logic              c_rgrant,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              flush,
  output logic              flush_done,
  output logic              fifo_wreq,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_rreq,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic [CNT_W-1:0]  occ,
  output logic              sched_full,
  output logic              sched_empty
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {RR_W0, RR_W1, RR_R} rr_t;

  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);

  state_t state;
  rr_t    rr;
  logic   in_run;
  logic   el_w0, el_w1, el_r;
  logic   g_w0, g_w1, g_r;
  // Read pipe: *_any tracks every issued read, cons1 only consumer reads.
  logic   rd_any1, rd_any2, rd_cons1;

  assign sched_full  = (occ == OCC_FULL);
  assign sched_empty = (occ == '0);
  assign in_run      = (state == RUN);

  assign el_w0 = in_run && !sched_full && p0_wvalid;
  assign el_w1 = in_run && !sched_full && p1_wvalid;
  assign el_r  = !sched_empty && (in_run ? c_rreq : (state == DRAIN));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    g_w0 = 1'b0;
    g_w1 = 1'b0;
    g_r  = 1'b0;
    case (rr)
      RR_W0: begin
        if      (el_w0) g_w0 = 1'b1;
        else if (el_w1) g_w1 = 1'b1;
        else if (el_r)  g_r  = 1'b1;
      end
      RR_W1: begin
        if      (el_w1) g_w1 = 1'b1;
        else if (el_r)  g_r  = 1'b1;
        else if (el_w0) g_w0 = 1'b1;
      end
      default: begin
        if      (el_r)  g_r  = 1'b1;
        else if (el_w0) g_w0 = 1'b1;
        else if (el_w1) g_w1 = 1'b1;
      end
    endcase
  end

  assign p0_wready = g_w0;
  assign p1_wready = g_w1;
  assign c_rgrant  = g_r && in_run;
  // The fifo presents rdata in the same cycle c_rvalid rises.
  assign c_rdata   = fifo_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RUN;
      rr         <= RR_W0;
      occ        <= '0;
      fifo_wreq  <= 1'b0;
      fifo_wdata <= '0;
      fifo_rreq  <= 1'b0;
      rd_any1    <= 1'b0;
      rd_any2    <= 1'b0;
      rd_cons1   <= 1'b0;
      c_rvalid   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      fifo_wreq <= g_w0 | g_w1;
      fifo_rreq <= g_r;
      if (g_w0)      fifo_wdata <= p0_wdata;
      else if (g_w1) fifo_wdata <= p1_wdata;

      if (g_w0 | g_w1) occ <= occ + CNT_W'(1);
      else if (g_r)    occ <= occ - CNT_W'(1);

      if (g_w0)      rr <= RR_W1;
      else if (g_w1) rr <= RR_R;
      else if (g_r)  rr <= RR_W0;

      rd_any1  <= g_r;
      rd_any2  <= rd_any1;
      rd_cons1 <= c_rgrant;
      c_rvalid <= rd_cons1;

      flush_done <= 1'b0;
      case (state)
        RUN:   if (flush) state <= DRAIN;
        // Wait for the pipe to empty so drained data cannot alias a later read.
        DRAIN: if (sched_empty && !rd_any1 && !rd_any2) begin
          state      <= DONE;
          flush_done <= 1'b1;
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_access_sched.sv
// Self-checking bench for fifo_access_sched: a behavioural fifo sits behind the
// scheduler and a scoreboard checks every c_rvalid word and its latency.
module tb_fifo_access_sched;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              p0_wvalid = 1'b0, p1_wvalid = 1'b0, c_rreq = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
  logic              p0_wready, p1_wready, c_rgrant, c_rvalid, flush_done;
  logic              fifo_wreq, fifo_rreq, sched_full, sched_empty;
  logic [DATA_W-1:0] c_rdata, fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]  occ;

  fifo_access_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .p0_wvalid(p0_wvalid), .p0_wdata(p0_wdata), .p0_wready(p0_wready),
    .p1_wvalid(p1_wvalid), .p1_wdata(p1_wdata), .p1_wready(p1_wready),
    .c_rreq(c_rreq), .c_rgrant(c_rgrant), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .flush(flush), .flush_done(flush_done),
    .fifo_wreq(fifo_wreq), .fifo_wdata(fifo_wdata), .fifo_rreq(fifo_rreq),
    .fifo_rdata(fifo_rdata), .occ(occ), .sched_full(sched_full), .sched_empty(sched_empty)
  );

  always #5 clk = ~clk;

  // Behavioural fifo: rdata registered on the edge that samples fifo_rreq.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [4:0]        wp, rp;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0; rp <= '0; fifo_rdata <= '0;
    end else begin
      if (fifo_wreq) begin mem[wp] <= fifo_wdata; wp <= wp + 5'd1; end
      if (fifo_rreq) begin fifo_rdata <= mem[rp]; rp <= rp + 5'd1; end
    end
  end

  typedef struct { logic [DATA_W-1:0] d; int cyc; } rd_t;
  logic [DATA_W-1:0] model_q[$];
  rd_t               exp_q[$];

  int n_vec = 0, n_err = 0, cyc = 0, n_wreq = 0, n_rreq = 0, n_rv = 0;
  logic [DATA_W-1:0] nd = 8'h40;
  logic s_p0r, s_p1r, s_cg, s_wreq, s_rreq, s_rvalid, s_done, s_full, s_empty;
  logic [CNT_W-1:0] s_occ;

  // One clock: sample at negedge, run the scoreboard, return 1 ns after posedge.
  task automatic cycle();
    rd_t e;
    @(negedge clk);
    cyc++;
    s_p0r = p0_wready; s_p1r = p1_wready; s_cg = c_rgrant;
    s_wreq = fifo_wreq; s_rreq = fifo_rreq; s_rvalid = c_rvalid;
    s_done = flush_done; s_full = sched_full; s_empty = sched_empty; s_occ = occ;
    if (fifo_wreq) n_wreq++;
    if (fifo_rreq) n_rreq++;
    n_vec++;
    if (fifo_wreq && fifo_rreq) begin
      n_err++;
      $display("FAIL req_exclusive cyc=%0d wreq=%b rreq=%b, required not both 1", cyc, fifo_wreq, fifo_rreq);
    end
    if (c_rvalid) begin
      n_rv++; n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rvalid_unexpected cyc=%0d rdata=%h, required no c_rvalid", cyc, c_rdata);
      end else begin
        e = exp_q.pop_front();
        if (c_rdata !== e.d || cyc != e.cyc + 2) begin
          n_err++;
          $display("FAIL rdata cyc=%0d got=%h required=%h at cyc=%0d", cyc, c_rdata, e.d, e.cyc + 2);
        end
      end
    end
    if (p0_wvalid && p0_wready) model_q.push_back(p0_wdata);
    if (p1_wvalid && p1_wready) model_q.push_back(p1_wdata);
    if (c_rgrant) begin
      n_vec++;
      if (model_q.size() == 0) begin
        n_err++;
        $display("FAIL grant_on_empty cyc=%0d c_rgrant=1, required 0", cyc);
      end else begin
        e.d = model_q.pop_front(); e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic put(input int port, input int n);
    int got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      p0_wvalid = (port == 0); p1_wvalid = (port == 1);
      p0_wdata = nd; p1_wdata = nd;
      cycle();
      if ((port == 0 && s_p0r) || (port == 1 && s_p1r)) begin got++; nd++; end
    end
    p0_wvalid = 1'b0; p1_wvalid = 1'b0;
    n_vec++;
    if (got != n) begin n_err++; $display("FAIL put_timeout port=%0d got=%0d required=%0d", port, got, n); end
  endtask

  task automatic get(input int n);
    int got = 0;
    c_rreq = 1'b1;
    for (int i = 0; i < 300 && got < n; i++) begin
      cycle();
      if (s_cg) got++;
    end
    c_rreq = 1'b0;
    repeat (3) cycle();
    n_vec++;
    if (got != n) begin n_err++; $display("FAIL get_timeout got=%0d required=%0d", got, n); end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({occ, sched_empty, sched_full, fifo_wreq, fifo_rreq, c_rvalid, flush_done} !== {6'd0, 6'b100000}) begin
      n_err++;
      $display("FAIL reset_state occ=%0d empty=%b full=%b wreq=%b rreq=%b rvalid=%b done=%b, required 0,1,0,0,0,0,0",
               occ, sched_empty, sched_full, fifo_wreq, fifo_rreq, c_rvalid, flush_done);
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_p0_writes();
    logic [7:0] vals [3];
    logic [4:0] hist;
    int r0 = n_rreq;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    p0_wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p0_wdata = vals[k];
      cycle();
      hist[k] = s_wreq;
      n_vec++;
      if (s_p0r !== 1'b1) begin n_err++; $display("FAIL p0_ready word=%0d got=%b required=1", k, s_p0r); end
    end
    p0_wvalid = 1'b0;
    cycle(); hist[3] = s_wreq;
    cycle(); hist[4] = s_wreq;
    n_vec += 3;
    if (hist !== 5'b01110) begin n_err++; $display("FAIL p0_wreq_pattern got=%b required=01110", hist); end
    if (s_occ !== 6'd3) begin n_err++; $display("FAIL p0_occ got=%0d required=3", s_occ); end
    if (n_rreq != r0) begin n_err++; $display("FAIL p0_no_rreq got=%0d required=0", n_rreq - r0); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [6];
    logic [2:0] code;
    put(1, 3);
    get(1);
    n_vec++;
    if (s_occ !== 6'd5) begin n_err++; $display("FAIL rr_pre_occ got=%0d required=5", s_occ); end
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001;
    exp_seq[3] = 3'b100; exp_seq[4] = 3'b010; exp_seq[5] = 3'b001;
    p0_wvalid = 1'b1; p1_wvalid = 1'b1; c_rreq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p0_wdata = nd; p1_wdata = nd;
      cycle();
      code = {s_p0r, s_p1r, s_cg};
      if (s_p0r || s_p1r) nd++;
      n_vec++;
      if (code !== exp_seq[k]) begin n_err++; $display("FAIL rr_grant step=%0d got=%b required=%b", k, code, exp_seq[k]); end
    end
    p0_wvalid = 1'b0; p1_wvalid = 1'b0; c_rreq = 1'b0;
    repeat (3) cycle();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_pending_reads got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_full();
    p0_wvalid = 1'b1; p1_wvalid = 1'b1;
    s_full = 1'b0;
    for (int i = 0; i < 80 && !s_full; i++) begin
      p0_wdata = nd; p1_wdata = nd;
      cycle();
      if (s_p0r || s_p1r) nd++;
    end
    n_vec += 2;
    if ({s_full, s_occ} !== {1'b1, 6'd32}) begin n_err++; $display("FAIL full_state full=%b occ=%0d required 1,32", s_full, s_occ); end
    if ({s_p0r, s_p1r} !== 2'b00) begin n_err++; $display("FAIL full_ready got=%b required=00", {s_p0r, s_p1r}); end
    c_rreq = 1'b1;
    cycle();
    n_vec++;
    if ({s_p0r, s_p1r, s_cg} !== 3'b001) begin n_err++; $display("FAIL full_read_only got=%b required=001", {s_p0r, s_p1r, s_cg}); end
    c_rreq = 1'b0;
    p0_wdata = nd; p1_wdata = nd;
    cycle();
    if (s_p0r || s_p1r) nd++;
    n_vec += 2;
    if (s_occ !== 6'd31) begin n_err++; $display("FAIL full_after_read_occ got=%0d required=31", s_occ); end
    if (!(s_p0r || s_p1r)) begin n_err++; $display("FAIL full_refill got=%b required a write grant", {s_p0r, s_p1r}); end
    p0_wvalid = 1'b0; p1_wvalid = 1'b0;
    get(32);
    n_vec++;
    if (s_empty !== 1'b1) begin n_err++; $display("FAIL drained_empty got=%b required=1", s_empty); end
  endtask

  task automatic test_empty();
    c_rreq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_vec++;
      if ({s_cg, s_rreq, s_rvalid} !== 3'b000) begin
        n_err++; $display("FAIL empty_read k=%0d grant/rreq/rvalid=%b required=000", k, {s_cg, s_rreq, s_rvalid});
      end
    end
    p0_wvalid = 1'b1; p1_wvalid = 1'b1; p0_wdata = nd; p1_wdata = nd;
    cycle();
    if (s_p0r || s_p1r) nd++;
    n_vec++;
    if ({s_p0r, s_p1r, s_cg} !== 3'b100) begin n_err++; $display("FAIL empty_all_req got=%b required=100", {s_p0r, s_p1r, s_cg}); end
    c_rreq = 1'b0;
    put(1, 3);
    cycle();
    n_vec++;
    if (s_occ !== 6'd4) begin n_err++; $display("FAIL flush_pre_occ got=%0d required=4", s_occ); end
  endtask

  task automatic test_flush();
    int r0 = n_rreq, rv0 = n_rv;
    logic any_ready = 1'b0, seen = 1'b0;
    logic [CNT_W-1:0] occ_at_done = '1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    model_q.delete();
    p0_wvalid = 1'b1; p0_wdata = nd;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      any_ready |= s_p0r;
      if (s_done) begin seen = 1'b1; occ_at_done = s_occ; end
    end
    n_vec += 5;
    if (!seen) begin n_err++; $display("FAIL flush_done_timeout got=0 required=1"); end
    if (occ_at_done !== 6'd0) begin n_err++; $display("FAIL flush_occ got=%0d required=0", occ_at_done); end
    if (n_rreq - r0 != 4) begin n_err++; $display("FAIL flush_rreq_count got=%0d required=4", n_rreq - r0); end
    if (any_ready) begin n_err++; $display("FAIL flush_producer_blocked got=1 required=0"); end
    if (n_rv != rv0) begin n_err++; $display("FAIL flush_rvalid got=%0d required=0", n_rv - rv0); end
    cycle();
    if (s_p0r) nd++;
    p0_wvalid = 1'b0;
    n_vec += 2;
    if (s_p0r !== 1'b1) begin n_err++; $display("FAIL flush_back_to_run got=%b required=1", s_p0r); end
    if (s_done !== 1'b0) begin n_err++; $display("FAIL flush_done_single got=%b required=0", s_done); end
    get(1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    n_vec++;
    if (s_done !== 1'b0) begin n_err++; $display("FAIL flush0_early got=%b required=0", s_done); end
    cycle();
    n_vec++;
    if (s_done !== 1'b1) begin n_err++; $display("FAIL flush0_done got=%b required=1", s_done); end
    cycle();
    n_vec++;
    if (s_done !== 1'b0) begin n_err++; $display("FAIL flush0_pulse got=%b required=0", s_done); end
  endtask

  task automatic test_flush_with_read();
    int rv0;
    logic seen = 1'b0;
    put(0, 2);
    rv0 = n_rv;
    c_rreq = 1'b1; flush = 1'b1;
    cycle();
    c_rreq = 1'b0; flush = 1'b0;
    model_q.delete();
    n_vec++;
    if (s_cg !== 1'b1) begin n_err++; $display("FAIL flush_read_grant got=%b required=1", s_cg); end
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      seen = s_done;
    end
    repeat (2) cycle();
    n_vec += 2;
    if (n_rv - rv0 != 1) begin n_err++; $display("FAIL flush_read_rvalid got=%0d required=1", n_rv - rv0); end
    if (!seen || exp_q.size() != 0) begin
      n_err++; $display("FAIL flush_read_complete done=%b pending=%0d required 1,0", seen, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    put(0, 4);
    c_rreq = 1'b1;
    cycle(); cycle();
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if ({occ, c_rvalid, fifo_rreq, fifo_wreq, flush_done, sched_empty} !== {6'd0, 5'b00001}) begin
      n_err++;
      $display("FAIL async_reset occ=%0d rvalid=%b rreq=%b wreq=%b done=%b empty=%b, required 0,0,0,0,0,1",
               occ, c_rvalid, fifo_rreq, fifo_wreq, flush_done, sched_empty);
    end
    c_rreq = 1'b0;
    model_q.delete(); exp_q.delete();
    @(posedge clk); #3 resetn = 1'b1;
    @(posedge clk); #1;
    repeat (4) cycle();
    n_vec++;
    if ({s_occ, s_rvalid} !== {6'd0, 1'b0}) begin
      n_err++; $display("FAIL post_reset occ=%0d rvalid=%b required 0,0", s_occ, s_rvalid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_p0_writes();
    test_round_robin();
    test_full();
    test_empty();
    test_flush();
    test_flush_with_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
